// File: rtl/vga_genlock_ctrl.sv
// vga_genlock_ctrl: qualifies the TRS-80 vertical sync and emits a delayed one-cycle
// genlock pulse that realigns the free-running 800x600 VGA raster to the Model I frame.
module vga_genlock_ctrl #(
    parameter int MIN_PERIOD  = 320000,
    parameter int MAX_PERIOD  = 350000,
    parameter int LOCK_FRAMES = 4,
    parameter int FILTER      = 4,
    parameter int OFFSET      = 0,
    parameter bit VS_POL      = 1'b0
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        trs_vsync,
    output logic        genlock,
    output logic        locked,
    output logic [18:0] period,
    output logic        period_vld
);
    typedef enum logic [1:0] {IDLE, SEARCH, TRACK, LOCKED} state_t;

    localparam logic [18:0] MIN_P  = 19'(MIN_PERIOD);
    localparam logic [18:0] MAX_P  = 19'(MAX_PERIOD);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [3:0]  FILT_N = 4'(FILTER - 1);
    localparam logic [15:0] OFS    = 16'(OFFSET);

    logic        vs_act;
    logic        sync1_q, sync2_q;
    logic        filt_q, filt_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic        edge_q, edge_d;
    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic [18:0] cnt_q, cnt_d;
    logic [18:0] period_q, period_d;
    logic        period_vld_q, period_vld_d;
    logic        pend_q, pend_d;
    logic [15:0] dly_q, dly_d;
    logic        locked_q;
    logic        good_per, timeout, fire, arm;

    // Normalise before the synchroniser so reset (all zero) means "inactive".
    assign vs_act = VS_POL ? trs_vsync : ~trs_vsync;

    always_comb begin
        fcnt_d = 4'd0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FILT_N) filt_d = sync2_q;
            else fcnt_d = fcnt_q + 4'd1;
        end
        edge_d = filt_d & ~filt_q;
    end

    assign good_per = (cnt_q >= MIN_P) && (cnt_q <= MAX_P - 19'd1);
    assign timeout  = (cnt_q == MAX_P) && !edge_q;
    assign fire     = pend_q && (dly_q == OFS);

    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        cnt_d        = (cnt_q == MAX_P) ? MAX_P : cnt_q + 19'd1;
        period_d     = period_q;
        period_vld_d = 1'b0;
        pend_d       = pend_q && !fire;
        dly_d        = pend_q ? dly_q + 16'd1 : dly_q;
        arm          = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            good_d  = 4'd0;
            cnt_d   = 19'd0;
            pend_d  = 1'b0;
            dly_d   = 16'd0;
        end else begin
            if (state_q != IDLE && edge_q) begin
                period_d     = cnt_q;
                period_vld_d = 1'b1;
                cnt_d        = 19'd1;
            end
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                    cnt_d   = 19'd0;
                end
                SEARCH: begin
                    if (edge_q) begin
                        state_d = TRACK;
                        good_d  = 4'd0;
                    end
                end
                TRACK: begin
                    if (edge_q) begin
                        good_d = good_per ? good_q + 4'd1 : 4'd0;
                        if (good_per && good_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                            arm     = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d = SEARCH;
                        good_d  = 4'd0;
                    end
                end
                LOCKED: begin
                    if (edge_q && good_per) begin
                        arm = 1'b1;
                    end else if (edge_q || timeout) begin
                        state_d = edge_q ? TRACK : SEARCH;
                        good_d  = 4'd0;
                        pend_d  = 1'b0;
                    end
                end
            endcase
            // A fresh arm restarts the delay and drops any older pending pulse.
            if (arm) begin
                pend_d = 1'b1;
                dly_d  = 16'd0;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            filt_q       <= 1'b0;
            fcnt_q       <= 4'd0;
            edge_q       <= 1'b0;
            state_q      <= IDLE;
            good_q       <= 4'd0;
            cnt_q        <= 19'd0;
            period_q     <= 19'd0;
            period_vld_q <= 1'b0;
            pend_q       <= 1'b0;
            dly_q        <= 16'd0;
            locked_q     <= 1'b0;
        end else begin
            sync1_q      <= vs_act;
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            edge_q       <= edge_d;
            state_q      <= state_d;
            good_q       <= good_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            pend_q       <= pend_d;
            dly_q        <= dly_d;
            locked_q     <= (state_q == LOCKED);
        end
    end

    assign genlock    = fire && (state_q == LOCKED);
    assign locked     = locked_q;
    assign period     = period_q;
    assign period_vld = period_vld_q;
endmodule
